write_back: RTL and testbench

//   MIPS write-back stage: MEM/WB pipeline register, load-data extraction and result select.

---
 rtl/write_back_if.sv | 36 +++
 rtl/write_back.sv | 82 ++++++++
 tb/tb_write_back.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/write_back_if.sv
// Memory-stage to write-back signal bundle: stage inputs plus the register-file
// write port and status outputs.
interface write_back_if #(
    parameter int len   = 32,
    parameter int NB    = $clog2(len),
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             stall;
    logic             flush;
    logic [1:0]       in_writeBack_bus;
    logic [len-1:0]   in_read_data;
    logic [len-1:0]   in_alu_result;
    logic [2:0]       in_load_type;
    logic [NB-1:0]    in_write_register;
    logic             RegWrite;
    logic [len-1:0]   write_data;
    logic [NB-1:0]    write_register;
    logic             out_valid;
    logic             misalign_err;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output in_valid, stall, flush, in_writeBack_bus, in_read_data,
               in_alu_result, in_load_type, in_write_register,
        input  RegWrite, write_data, write_register, out_valid,
               misalign_err, retired_count
    );

    modport slave (
        input  in_valid, stall, flush, in_writeBack_bus, in_read_data,
               in_alu_result, in_load_type, in_write_register,
        output RegWrite, write_data, write_register, out_valid,
               misalign_err, retired_count
    );
endinterface

// File: rtl/write_back.sv
// MIPS write-back stage: MEM/WB register, load extraction, result select,
// misaligned-load detection and retired-instruction counter.
module write_back #(
    parameter int len   = 32,
    parameter int NB    = $clog2(len),
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    write_back_if.slave wb
);
    typedef struct packed {
        logic           reg_write;
        logic           mem_to_reg;
        logic [len-1:0] read_data;
        logic [len-1:0] alu;
        logic [2:0]     load_type;
        logic [NB-1:0]  rd;
    } stage_t;

    stage_t           stg;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0]       off;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic             is_byte;
    logic             is_half;
    logic             misalign;
    logic [len-1:0]   load_data;

    // Payload is only captured for valid instructions so the write port holds
    // its last values while the stage is empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg     <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (wb.flush) begin
                valid_q <= 1'b0;
            end else if (!wb.stall) begin
                valid_q <= wb.in_valid;
                if (wb.in_valid) begin
                    stg.reg_write  <= wb.in_writeBack_bus[1];
                    stg.mem_to_reg <= wb.in_writeBack_bus[0];
                    stg.read_data  <= wb.in_read_data;
                    stg.alu        <= wb.in_alu_result;
                    stg.load_type  <= wb.in_load_type;
                    stg.rd         <= wb.in_write_register;
                end
            end
            if (valid_q && !wb.stall)
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        off     = stg.alu[1:0];
        byte_v  = stg.read_data[{off, 3'b000} +: 8];
        half_v  = off[1] ? stg.read_data[31:16] : stg.read_data[15:0];
        is_byte = (stg.load_type == 3'b000) || (stg.load_type == 3'b100);
        is_half = (stg.load_type == 3'b001) || (stg.load_type == 3'b101);
        case (stg.load_type)
            3'b000:  load_data = {{(len-8){byte_v[7]}}, byte_v};
            3'b100:  load_data = {{(len-8){1'b0}}, byte_v};
            3'b001:  load_data = {{(len-16){half_v[15]}}, half_v};
            3'b101:  load_data = {{(len-16){1'b0}}, half_v};
            default: load_data = stg.read_data;  // lw and unused encodings
        endcase
        misalign = valid_q & stg.mem_to_reg &
                   ((is_half & off[0]) | (!is_byte & !is_half & (off != 2'b00)));
    end

    assign wb.write_data     = stg.mem_to_reg ? load_data : stg.alu;
    assign wb.write_register = stg.rd;
    assign wb.out_valid      = valid_q;
    assign wb.misalign_err   = misalign;
    assign wb.RegWrite       = valid_q & stg.reg_write & (stg.rd != '0) & ~misalign;
    assign wb.retired_count  = cnt_q;
endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: ALU results, load extraction, misalignment,
// $0 suppression, stall/flush, async reset and counter wrap.
module tb_write_back;
    logic clk;
    logic reset;
    int   tests;
    int   failed;
    logic mv;
    int   mcnt;

    write_back_if #(.len(32), .CNT_W(32)) bus ();
    write_back_if #(.len(32), .CNT_W(3))  sbus ();

    write_back #(.len(32), .CNT_W(32)) dut (.clk(clk), .reset(reset), .wb(bus.slave));
    write_back #(.len(32), .CNT_W(3))  dut_s (.clk(clk), .reset(reset), .wb(sbus.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Clock edge on the main DUT with a tiny valid/count model alongside.
    task automatic step();
        if (mv && !bus.stall) mcnt++;
        mv = bus.flush ? 1'b0 : (bus.stall ? mv : bus.in_valid);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] wbb, input logic [31:0] rdat,
                         input logic [31:0] alu, input logic [2:0] lt, input logic [4:0] rd);
        bus.in_valid          = 1'b1;
        bus.in_writeBack_bus  = wbb;
        bus.in_read_data      = rdat;
        bus.in_alu_result     = alu;
        bus.in_load_type      = lt;
        bus.in_write_register = rd;
    endtask

    task automatic load_chk(input string tag, input logic [31:0] alu, input logic [2:0] lt,
                            input logic [31:0] exp_wd);
        drive(2'b11, 32'h80FF_7F81, alu, lt, 5'd7);
        step();
        chk({tag, "_data"}, bus.write_data, exp_wd);
        chk({tag, "_we"}, {31'b0, bus.RegWrite}, 32'd1);
        chk({tag, "_cnt"}, bus.retired_count, mcnt);
    endtask

    initial begin
        tests = 0; failed = 0; mv = 1'b0; mcnt = 0;
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.in_writeBack_bus = 2'b00; bus.in_read_data = '0; bus.in_alu_result = '0;
        bus.in_load_type = 3'b000; bus.in_write_register = '0;
        sbus.in_valid = 1'b0; sbus.stall = 1'b0; sbus.flush = 1'b0;
        sbus.in_writeBack_bus = 2'b10; sbus.in_read_data = '0; sbus.in_alu_result = 32'h1;
        sbus.in_load_type = 3'b011; sbus.in_write_register = 5'd1;
        #12;
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_we", {31'b0, bus.RegWrite}, 32'd0);
        chk("rst_wd", bus.write_data, 32'd0);
        chk("rst_wr", {27'b0, bus.write_register}, 32'd0);
        chk("rst_mis", {31'b0, bus.misalign_err}, 32'd0);
        chk("rst_cnt", bus.retired_count, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // ALU result
        drive(2'b10, 32'h0, 32'h0000_1234, 3'b011, 5'd5);
        step();
        chk("alu_we", {31'b0, bus.RegWrite}, 32'd1);
        chk("alu_wr", {27'b0, bus.write_register}, 32'd5);
        chk("alu_wd", bus.write_data, 32'h0000_1234);
        chk("alu_cnt0", bus.retired_count, 32'd0);

        // Loads from 80FF_7F81
        load_chk("lb0", 32'h0, 3'b000, 32'hFFFF_FF81);
        chk("alu_cnt1", bus.retired_count, 32'd1);
        load_chk("lbu3", 32'h3, 3'b100, 32'h0000_0080);
        load_chk("lh2", 32'h2, 3'b001, 32'hFFFF_80FF);
        load_chk("lhu0", 32'h0, 3'b101, 32'h0000_7F81);
        load_chk("lw0", 32'h0, 3'b011, 32'h80FF_7F81);
        load_chk("lt010", 32'h0, 3'b010, 32'h80FF_7F81);
        load_chk("lb2", 32'h2, 3'b000, 32'hFFFF_FFFF);

        // Misaligned loads
        drive(2'b11, 32'h80FF_7F81, 32'h1, 3'b001, 5'd7);
        step();
        chk("mis_lh_err", {31'b0, bus.misalign_err}, 32'd1);
        chk("mis_lh_we", {31'b0, bus.RegWrite}, 32'd0);
        chk("mis_lh_wd", bus.write_data, 32'h0000_7F81);
        drive(2'b11, 32'h80FF_7F81, 32'h2, 3'b011, 5'd7);
        step();
        chk("mis_lw_err", {31'b0, bus.misalign_err}, 32'd1);
        chk("mis_lw_we", {31'b0, bus.RegWrite}, 32'd0);
        chk("mis_lw_cnt", bus.retired_count, mcnt);

        // Write to $0 suppressed
        drive(2'b10, 32'h0, 32'h0000_0055, 3'b011, 5'd0);
        step();
        chk("r0_we", {31'b0, bus.RegWrite}, 32'd0);
        chk("r0_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("r0_mis", {31'b0, bus.misalign_err}, 32'd0);
        chk("r0_wd", bus.write_data, 32'h0000_0055);

        // Stall for three cycles with new inputs presented
        drive(2'b10, 32'h0, 32'h0000_0999, 3'b011, 5'd9);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_wd", bus.write_data, 32'h0000_0055);
            chk("stall_wr", {27'b0, bus.write_register}, 32'd0);
            chk("stall_cnt", bus.retired_count, mcnt);
        end
        chk("stall_cnt_abs", bus.retired_count, 32'd10);

        // Stall and flush together: flush wins
        bus.flush = 1'b1;
        step();
        chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("flush_we", {31'b0, bus.RegWrite}, 32'd0);
        chk("flush_wd_hold", bus.write_data, 32'h0000_0055);
        bus.stall = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0;
        step();
        chk("idle_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("idle_wd_hold", bus.write_data, 32'h0000_0055);
        chk("idle_cnt", bus.retired_count, mcnt);

        // Async reset mid-stream
        drive(2'b10, 32'h0, 32'h0000_ABCD, 3'b011, 5'd3);
        step();
        chk("pre_rst_we", {31'b0, bus.RegWrite}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("arst_we", {31'b0, bus.RegWrite}, 32'd0);
        chk("arst_wd", bus.write_data, 32'd0);
        chk("arst_wr", {27'b0, bus.write_register}, 32'd0);
        chk("arst_cnt", bus.retired_count, 32'd0);
        bus.in_valid = 1'b0;
        mv = 1'b0; mcnt = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Counter wrap on the narrow-counter instance
        sbus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
        end
        chk("wrap_pre", {29'b0, sbus.retired_count}, 32'd7);
        @(posedge clk); #1;
        chk("wrap_zero", {29'b0, sbus.retired_count}, 32'd0);
        chk("wrap_we", {31'b0, sbus.RegWrite}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #50000;
        failed++;
        $display("FAIL timeout tests=%0d", tests);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $fatal(1, "timeout");
    end
endmodule
